// File: rtl/fp_cvt_pkg.sv
// fp_cvt_pkg: shared definitions for the floating-point to integer converters.
//   - IEEE-754 double field widths and exponent bias
//   - RISC-V rounding-mode encodings
//   - fflags bit positions ({NV,DZ,OF,UF,NX})
//   - converter FSM state encoding
package fp_cvt_pkg;

  localparam int NEXP = 11;
  localparam int NSIG = 52;
  localparam int BIAS = 1023;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_round_decide.sv
// fp_round_decide: combinational round-increment decision for float->int
// conversion.
//   sign : operand sign (1 = negative)
//   lsb  : least significant bit of the truncated integer magnitude
//   g    : guard bit (first bit below the integer lsb)
//   s    : sticky bit (OR of all bits below the guard)
//   rm   : RISC-V rounding mode; reserved encodings round as RNE
//   inc  : 1 when the truncated magnitude must be incremented
module fp_round_decide
  import fp_cvt_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  input  logic [2:0] rm,
  output logic       inc
);

  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
  end

endmodule

// File: rtl/fp_cvt_wu_d.sv
// fp_cvt_wu_d: IEEE-754 double to 32-bit unsigned integer (RISC-V FCVT.WU.D).
// Multi-cycle: the mantissa is right-shifted up to 8 bits per cycle, then
// rounded in a single cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (d, rm)
//   out_valid/out_ready : result handshake (wu, fflags)
//   fflags              : {NV,DZ,OF,UF,NX}, only NV and NX can be set
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | aligning mantissa to the integer point, collecting guard/sticky
// ROUND | applying rounding, saturation and flags; registers the result
// DONE  | result presented, waiting for out_ready
module fp_cvt_wu_d #(
  parameter int NEXP = fp_cvt_pkg::NEXP,
  parameter int NSIG = fp_cvt_pkg::NSIG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] d,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wu,
  output logic [4:0]  fflags
);
  import fp_cvt_pkg::*;

  localparam int MW = NSIG + 1;
  localparam int CW = $clog2(MW);
  localparam int WW = 32;

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [2:0]      rm_q, rm_d;
  logic [MW-1:0]   mant_q, mant_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            guard_q, guard_d;
  logic            sticky_q, sticky_d;
  logic            forced_q, forced_d;
  logic            forced_ones_q, forced_ones_d;
  logic [WW-1:0]   wu_q, wu_d;
  logic [4:0]      fflags_q, fflags_d;

  logic [NEXP-1:0] exp_f;
  logic [NSIG-1:0] frac_f;
  logic            in_sign;
  int              e_i;

  logic [3:0]      step;
  logic [MW-1:0]   low_mask;
  logic            step_g;
  logic            step_s;
  logic            inc;
  logic [WW:0]     sum;

  assign exp_f   = d[NSIG +: NEXP];
  assign frac_f  = d[NSIG-1:0];
  assign in_sign = d[63];

  always_comb begin
    e_i = int'(exp_f) - BIAS;
  end

  // One alignment step: shift by min(8, remaining). The new guard is the
  // highest bit shifted out; everything below it joins the sticky.
  always_comb begin
    step     = (rem_q >= CW'(8)) ? 4'd8 : 4'(rem_q);
    low_mask = (MW'(1) << (step - 4'd1)) - MW'(1);
    step_g   = mant_q[step - 4'd1];
    step_s   = |(mant_q & low_mask);
  end

  // After alignment the integer part fits in the low 32 bits (shift >= 21).
  fp_round_decide u_round (
    .sign (sign_q),
    .lsb  (mant_q[0]),
    .g    (guard_q),
    .s    (sticky_q),
    .rm   (rm_q),
    .inc  (inc)
  );

  assign sum = {1'b0, mant_q[WW-1:0]} + {{WW{1'b0}}, inc};

  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    rm_d          = rm_q;
    mant_d        = mant_q;
    rem_d         = rem_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    forced_d      = forced_q;
    forced_ones_d = forced_ones_q;
    wu_d          = wu_q;
    fflags_d      = fflags_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d        = in_sign;
          rm_d          = rm;
          mant_d        = {1'b1, frac_f};
          rem_d         = '0;
          guard_d       = 1'b0;
          sticky_d      = 1'b0;
          forced_d      = 1'b0;
          forced_ones_d = 1'b0;
          state_d       = ST_ROUND;
          if (exp_f == '1) begin
            // NaN saturates high regardless of sign; infinities by sign.
            mant_d        = '0;
            forced_d      = 1'b1;
            forced_ones_d = (frac_f != '0) | ~in_sign;
          end else if (exp_f == '0) begin
            // Zero leaves nothing; a subnormal is a pure sticky fraction.
            mant_d   = '0;
            sticky_d = |frac_f;
          end else if (e_i <= -2) begin
            mant_d   = '0;
            sticky_d = 1'b1;
          end else if (e_i == -1) begin
            // Value in [0.5,1): the hidden one is the guard bit.
            mant_d   = '0;
            guard_d  = 1'b1;
            sticky_d = |frac_f;
          end else if (e_i >= WW) begin
            mant_d        = '0;
            forced_d      = 1'b1;
            forced_ones_d = ~in_sign;
          end else begin
            rem_d   = CW'(NSIG - e_i);
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        mant_d   = mant_q >> step;
        guard_d  = step_g;
        sticky_d = sticky_q | guard_q | step_s;
        rem_d    = rem_q - CW'(step);
        if (rem_q <= CW'(8)) state_d = ST_ROUND;
      end

      ST_ROUND: begin
        wu_d     = '0;
        fflags_d = '0;
        if (forced_q) begin
          wu_d              = forced_ones_q ? '1 : '0;
          fflags_d[FLAG_NV] = 1'b1;
        end else if (!sign_q) begin
          if (sum[WW]) begin
            wu_d              = '1;
            fflags_d[FLAG_NV] = 1'b1;
          end else begin
            wu_d              = sum[WW-1:0];
            fflags_d[FLAG_NX] = guard_q | sticky_q;
          end
        end else if ((mant_q[WW-1:0] == '0) && !inc) begin
          // Negative value rounding to zero is representable, just inexact.
          fflags_d[FLAG_NX] = guard_q | sticky_q;
        end else begin
          fflags_d[FLAG_NV] = 1'b1;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sign_q        <= 1'b0;
      rm_q          <= '0;
      mant_q        <= '0;
      rem_q         <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      forced_q      <= 1'b0;
      forced_ones_q <= 1'b0;
      wu_q          <= '0;
      fflags_q      <= '0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      rm_q          <= rm_d;
      mant_q        <= mant_d;
      rem_q         <= rem_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      forced_q      <= forced_d;
      forced_ones_q <= forced_ones_d;
      wu_q          <= wu_d;
      fflags_q      <= fflags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign wu        = wu_q;
  assign fflags    = fflags_q;

endmodule

// File: doc/fp_cvt_wu_d.md
FP_CVT_WU_D -- requirements
Module: fp_cvt_wu_d

Interface
REQ-001 SHALL have parameter NEXP, default 11, meaning double exponent width.
REQ-002 SHALL have parameter NSIG, default 52, meaning double fraction width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-007 SHALL have port d, input, 64 bits: IEEE-754 double operand.
REQ-008 SHALL have port rm, input, 3 bits: RISC-V rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM); 101-111 are treated as RNE.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port wu, output, 32 bits: unsigned integer result.
REQ-012 SHALL have port fflags, output, 5 bits: {NV,DZ,OF,UF,NX}; DZ/OF/UF are always 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT, ROUND and DONE; in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 SHALL accept the operand when in_valid&in_ready: latch sign, e=exp-1023, mant={1,frac} (53b) and rm.
REQ-015 Normal path (exp!=0x7FF and 0<=e<=31): IDLE->SHIFT, with shift count sh=52-e (21..52).
REQ-016 SHIFT SHALL right-shift mant by min(8,remaining) per cycle, tracking guard (last bit shifted out) and sticky (OR of all earlier shifted-out bits), for n=ceil(sh/8) cycles (3..7), then go to ROUND.
REQ-017 Special path SHALL go IDLE->ROUND directly, with preset values: zero (exp=0, frac=0) -> int=0, G=0, S=0; subnormal, or e<=-2 -> int=0, G=0, S=1; e=-1 -> int=0, G=1, S=|frac; NaN -> forced result 0xFFFFFFFF with NV; +Inf or positive e>=32 -> 0xFFFFFFFF with NV; -Inf or negative e>=32 -> 0 with NV.
REQ-018 ROUND SHALL compute inc: RNE G&(S|int[0]); RTZ 0; RDN sign&(G|S); RUP ~sign&(G|S); RMM G.
REQ-019 Positive: result=int+inc in 33 bits; a carry out of bit 31 SHALL give wu=0xFFFFFFFF and NV=1, NX=0.
REQ-020 Negative: if int==0 and inc==0, wu=0 and NX=G|S with NV=0; otherwise wu=0, NV=1 and NX=0.
REQ-021 NX SHALL be G|S whenever NV=0; NX SHALL be 0 whenever NV=1.
REQ-022 ROUND SHALL register wu/fflags and go to DONE; latency from the accept edge to out_valid SHALL be n+1 cycles (1 on the special path).
REQ-023 DONE SHALL hold wu, fflags and out_valid stable until out_ready=1, then go to IDLE; no operand is accepted in the same cycle.
REQ-024 wu and fflags SHALL keep their last values in IDLE.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, wu=0, fflags=0, and clear the shift counter, guard and sticky.
REQ-026 rst asserted mid-operation SHALL discard the in-flight operand; no out_valid SHALL follow.

Structure
REQ-027 SHALL take NEXP, NSIG, BIAS (1023), the rm encodings, the fflags bit indices and the FSM state encoding from shared package fp_cvt_pkg.
REQ-028 SHALL place the round-increment decision (REQ-018) in combinational sub-module fp_round_decide (inputs sign, lsb, G, S, rm; output inc), reusable by other converters.

Verification
REQ-029 d=0x41EFFFFFFFE00000 (4294967295.0), RNE -> wu=0xFFFFFFFF, fflags=0, latency 4.
REQ-030 d=0x41F0000000000000 (2^32) -> wu=0xFFFFFFFF, fflags=0x10; d=0x7FF8000000000000 (NaN) -> wu=0xFFFFFFFF, fflags=0x10, latency 1.
REQ-031 d=0x4004000000000000 (2.5): RNE -> wu=2, fflags=0x01; RMM -> 3, fflags=0x01; RUP -> 3; RTZ -> 2; each with latency 8.
REQ-032 d=0xBFE0000000000000 (-0.5): RNE -> wu=0, fflags=0x01; RDN -> wu=0, fflags=0x10; d=0x8000000000000000 -> wu=0, fflags=0.
REQ-033 d=0x3FF0000000000000 (1.0) with out_ready held low 5 cycles -> wu=1 held stable with out_valid; in_ready=0 until the handshake completes.
REQ-034 rst pulsed during the SHIFT state -> out_valid never asserts, in_ready=1 and outputs zero the next cycle.
